// File: rtl/alu_seq_ctrl_if.sv
// Command, result and ALU-side bus of the accumulator sequencer.
// The slave modport is the sequencer itself; master is the host plus ALU.
interface alu_seq_ctrl_if;
    logic       cmd_valid;
    logic       cmd_ready;
    logic       cmd_load;
    logic [2:0] cmd_op;
    logic [7:0] cmd_data;

    logic       res_valid;
    logic       res_ready;
    logic [7:0] res_data;
    logic [7:0] res_acc;
    logic       res_c;
    logic       res_ov;
    logic       res_zero;
    logic [7:0] op_count;

    logic [7:0] alu_x;
    logic [7:0] alu_y;
    logic [2:0] alu_op;
    logic [7:0] alu_s;
    logic       alu_c;
    logic       alu_ov;

    modport slave (
        input  cmd_valid, cmd_load, cmd_op, cmd_data, res_ready,
        input  alu_s, alu_c, alu_ov,
        output cmd_ready, res_valid, res_data, res_acc, res_c, res_ov,
        output res_zero, op_count, alu_x, alu_y, alu_op
    );

    modport master (
        output cmd_valid, cmd_load, cmd_op, cmd_data, res_ready,
        output alu_s, alu_c, alu_ov,
        input  cmd_ready, res_valid, res_data, res_acc, res_c, res_ov,
        input  res_zero, op_count, alu_x, alu_y, alu_op
    );
endinterface

// File: rtl/alu_seq_ctrl.sv
// Accumulator sequencer: accepts load/ALU commands, drives an external
// combinational ALU for one settle cycle, and presents a held result.
module alu_seq_ctrl (
    input  logic          clk,
    input  logic          rst,
    alu_seq_ctrl_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

    state_t     state;
    logic [7:0] acc;
    logic [7:0] res_data;
    logic       res_c;
    logic       res_ov;
    logic       res_zero;
    logic       res_valid;
    logic [7:0] op_count;
    logic [7:0] alu_x;
    logic [7:0] alu_y;
    logic [2:0] alu_op;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            acc       <= 8'h00;
            res_data  <= 8'h00;
            res_c     <= 1'b0;
            res_ov    <= 1'b0;
            res_zero  <= 1'b0;
            res_valid <= 1'b0;
            alu_x     <= 8'h00;
            alu_y     <= 8'h00;
            alu_op    <= 3'b000;
            op_count  <= 8'h00;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.cmd_valid) begin
                        if (bus.cmd_load) begin
                            acc       <= bus.cmd_data;
                            res_data  <= bus.cmd_data;
                            res_c     <= 1'b0;
                            res_ov    <= 1'b0;
                            res_zero  <= (bus.cmd_data == 8'h00);
                            res_valid <= 1'b1;
                            state     <= RESP;
                        end else begin
                            alu_x  <= acc;
                            alu_y  <= bus.cmd_data;
                            alu_op <= bus.cmd_op;
                            state  <= ISSUE;
                        end
                    end
                end
                ISSUE: begin
                    res_data  <= bus.alu_s;
                    res_c     <= bus.alu_c;
                    res_ov    <= bus.alu_ov;
                    res_zero  <= (bus.alu_s == 8'h00);
                    res_valid <= 1'b1;
                    // Compare ops (110, 111) report a flag but keep the accumulator.
                    if (alu_op <= 3'b101)
                        acc <= bus.alu_s;
                    state <= RESP;
                end
                RESP: begin
                    if (bus.res_ready) begin
                        res_valid <= 1'b0;
                        op_count  <= op_count + 8'd1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    res_valid <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

    // Ready is combinational so it drops in the very cycle reset is raised.
    assign bus.cmd_ready = (state == IDLE) && !rst;
    assign bus.res_valid = res_valid;
    assign bus.res_data  = res_data;
    assign bus.res_acc   = acc;
    assign bus.res_c     = res_c;
    assign bus.res_ov    = res_ov;
    assign bus.res_zero  = res_zero;
    assign bus.op_count  = op_count;
    assign bus.alu_x     = alu_x;
    assign bus.alu_y     = alu_y;
    assign bus.alu_op    = alu_op;
endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Directed bench for alu_seq_ctrl with a behavioural 8-bit team ALU on the bus.
module tb_alu_seq_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   nchk = 0;
    int   nfail = 0;
    int   lat;

    alu_seq_ctrl_if bus ();

    alu_seq_ctrl dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    // Team ALU: add/sub carry is bit 8 of the 9-bit result, ov is signed overflow.
    always_comb begin
        logic [8:0] w;
        w          = 9'h000;
        bus.alu_s  = 8'h00;
        bus.alu_c  = 1'b0;
        bus.alu_ov = 1'b0;
        case (bus.alu_op)
            3'b000: begin
                w          = {1'b0, bus.alu_x} + {1'b0, bus.alu_y};
                bus.alu_s  = w[7:0];
                bus.alu_c  = w[8];
                bus.alu_ov = (bus.alu_x[7] == bus.alu_y[7]) && (w[7] != bus.alu_x[7]);
            end
            3'b001: begin
                w          = {1'b0, bus.alu_x} - {1'b0, bus.alu_y};
                bus.alu_s  = w[7:0];
                bus.alu_c  = w[8];
                bus.alu_ov = (bus.alu_x[7] != bus.alu_y[7]) && (w[7] != bus.alu_x[7]);
            end
            3'b010: bus.alu_s = ~bus.alu_x;
            3'b011: bus.alu_s = bus.alu_x & bus.alu_y;
            3'b100: bus.alu_s = bus.alu_x | bus.alu_y;
            3'b101: bus.alu_s = bus.alu_x ^ bus.alu_y;
            3'b110: bus.alu_s = {7'b0, ($signed(bus.alu_x) < $signed(bus.alu_y))};
            default: bus.alu_s = {7'b0, (bus.alu_x == bus.alu_y)};
        endcase
    end

    // Present a command, wait for ready, and return at the negedge after acceptance.
    task automatic send_cmd(input logic load, input logic [2:0] op, input logic [7:0] data);
        int n;
        @(negedge clk);
        bus.cmd_valid = 1'b1;
        bus.cmd_load  = load;
        bus.cmd_op    = op;
        bus.cmd_data  = data;
        n = 0;
        while (!bus.cmd_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        nchk++;
        if (!bus.cmd_ready) begin
            $display("FAIL accept_timeout: cmd_ready=%b required 1", bus.cmd_ready);
            nfail++;
        end
        @(posedge clk);
        @(negedge clk);
        bus.cmd_valid = 1'b0;
    endtask

    // lat = number of edges after acceptance until res_valid is seen at an edge.
    task automatic wait_res();
        lat = 1;
        while (!bus.res_valid && lat < 10) begin
            @(negedge clk);
            lat++;
        end
        nchk++;
        if (!bus.res_valid) begin
            $display("FAIL res_timeout: res_valid=%b required 1", bus.res_valid);
            nfail++;
        end
    endtask

    task automatic run_cmd(input logic load, input logic [2:0] op, input logic [7:0] data);
        send_cmd(load, op, data);
        wait_res();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        nchk++; if (bus.cmd_ready !== 1'b0) begin $display("FAIL rst_cmd_ready: got %b want 0", bus.cmd_ready); nfail++; end
        nchk++; if (bus.res_valid !== 1'b0) begin $display("FAIL rst_res_valid: got %b want 0", bus.res_valid); nfail++; end
        nchk++; if (bus.res_acc !== 8'h00) begin $display("FAIL rst_acc: got %h want 00", bus.res_acc); nfail++; end
        nchk++; if (bus.op_count !== 8'h00) begin $display("FAIL rst_op_count: got %h want 00", bus.op_count); nfail++; end
        nchk++; if ({bus.alu_x, bus.alu_y, bus.alu_op} !== 19'h0) begin
            $display("FAIL rst_alu_regs: got %h %h %b want 00 00 000", bus.alu_x, bus.alu_y, bus.alu_op); nfail++; end
        nchk++; if ({bus.res_data, bus.res_c, bus.res_ov, bus.res_zero} !== 11'h0) begin
            $display("FAIL rst_res: got %h %b%b%b want 00 000", bus.res_data, bus.res_c, bus.res_ov, bus.res_zero); nfail++; end
        rst = 1'b0;
        @(negedge clk);
        nchk++; if (bus.cmd_ready !== 1'b1) begin $display("FAIL rst_release_ready: got %b want 1", bus.cmd_ready); nfail++; end
    endtask

    task automatic test_add();
        run_cmd(1'b1, 3'b000, 8'h05);
        nchk++; if (lat !== 1) begin $display("FAIL load_latency: got %0d want 1", lat); nfail++; end
        nchk++; if (bus.res_data !== 8'h05) begin $display("FAIL load_data: got %h want 05", bus.res_data); nfail++; end
        nchk++; if (bus.alu_x !== 8'h00 || bus.alu_y !== 8'h00) begin
            $display("FAIL load_alu_hold: got x=%h y=%h want 00 00", bus.alu_x, bus.alu_y); nfail++; end
        run_cmd(1'b0, 3'b000, 8'h03);
        nchk++; if (lat !== 2) begin $display("FAIL alu_latency: got %0d want 2", lat); nfail++; end
        nchk++; if (bus.res_data !== 8'h08) begin $display("FAIL add_data: got %h want 08", bus.res_data); nfail++; end
        nchk++; if (bus.res_acc !== 8'h08) begin $display("FAIL add_acc: got %h want 08", bus.res_acc); nfail++; end
        nchk++; if ({bus.res_c, bus.res_ov, bus.res_zero} !== 3'b000) begin
            $display("FAIL add_flags: got c/ov/z=%b%b%b want 000", bus.res_c, bus.res_ov, bus.res_zero); nfail++; end
        @(negedge clk);
        nchk++; if (bus.op_count !== 8'h02) begin $display("FAIL add_op_count: got %h want 02", bus.op_count); nfail++; end
    endtask

    task automatic test_overflow();
        run_cmd(1'b1, 3'b000, 8'h7F);
        run_cmd(1'b0, 3'b000, 8'h01);
        nchk++; if (bus.res_data !== 8'h80) begin $display("FAIL ovf_data: got %h want 80", bus.res_data); nfail++; end
        nchk++; if (bus.res_ov !== 1'b1 || bus.res_c !== 1'b0) begin
            $display("FAIL ovf_flags: got ov=%b c=%b want 1 0", bus.res_ov, bus.res_c); nfail++; end
        nchk++; if (bus.res_acc !== 8'h80) begin $display("FAIL ovf_acc: got %h want 80", bus.res_acc); nfail++; end
    endtask

    task automatic test_sub_cmp();
        run_cmd(1'b1, 3'b000, 8'h03);
        run_cmd(1'b0, 3'b001, 8'h05);
        nchk++; if (bus.res_data !== 8'hFE || bus.res_acc !== 8'hFE) begin
            $display("FAIL sub: got data=%h acc=%h want FE FE", bus.res_data, bus.res_acc); nfail++; end
        run_cmd(1'b0, 3'b110, 8'h01);
        nchk++; if (bus.res_data !== 8'h01 || bus.res_acc !== 8'hFE) begin
            $display("FAIL slt: got data=%h acc=%h want 01 FE", bus.res_data, bus.res_acc); nfail++; end
        run_cmd(1'b0, 3'b111, 8'hFE);
        nchk++; if (bus.res_data !== 8'h01 || bus.res_acc !== 8'hFE) begin
            $display("FAIL eq: got data=%h acc=%h want 01 FE", bus.res_data, bus.res_acc); nfail++; end
        nchk++; if (bus.alu_x !== 8'hFE || bus.alu_y !== 8'hFE || bus.alu_op !== 3'b111) begin
            $display("FAIL eq_alu_regs: got %h %h %b want FE FE 111", bus.alu_x, bus.alu_y, bus.alu_op); nfail++; end
    endtask

    task automatic test_zero();
        run_cmd(1'b1, 3'b000, 8'h0F);
        run_cmd(1'b0, 3'b101, 8'h0F);
        nchk++; if (bus.res_data !== 8'h00 || bus.res_zero !== 1'b1) begin
            $display("FAIL xor_zero: got data=%h z=%b want 00 1", bus.res_data, bus.res_zero); nfail++; end
        nchk++; if (bus.res_acc !== 8'h00) begin $display("FAIL xor_acc: got %h want 00", bus.res_acc); nfail++; end
    endtask

    task automatic test_backpressure();
        logic [7:0] cnt0;
        @(negedge clk);
        cnt0 = bus.op_count;
        bus.res_ready = 1'b0;
        run_cmd(1'b1, 3'b000, 8'h42);
        bus.cmd_valid = 1'b1;
        bus.cmd_load  = 1'b1;
        bus.cmd_data  = 8'h99;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            nchk++; if (bus.res_valid !== 1'b1 || bus.res_data !== 8'h42 || bus.res_acc !== 8'h42) begin
                $display("FAIL bp_hold[%0d]: got v=%b data=%h acc=%h want 1 42 42", i, bus.res_valid, bus.res_data, bus.res_acc); nfail++; end
            nchk++; if (bus.cmd_ready !== 1'b0 || bus.op_count !== cnt0) begin
                $display("FAIL bp_ready_cnt[%0d]: got rdy=%b cnt=%h want 0 %h", i, bus.cmd_ready, bus.op_count, cnt0); nfail++; end
        end
        bus.cmd_valid = 1'b0;
        bus.res_ready = 1'b1;
        @(negedge clk);
        nchk++; if (bus.op_count !== cnt0 + 8'd1 || bus.res_valid !== 1'b0 || bus.res_acc !== 8'h42) begin
            $display("FAIL bp_release: got cnt=%h v=%b acc=%h want %h 0 42", bus.op_count, bus.res_valid, bus.res_acc, cnt0 + 8'd1); nfail++; end
    endtask

    task automatic test_reset_mid();
        run_cmd(1'b1, 3'b000, 8'h20);
        send_cmd(1'b0, 3'b000, 8'h10);
        rst = 1'b1;
        @(negedge clk);
        nchk++; if (bus.res_acc !== 8'h00 || bus.res_valid !== 1'b0 || bus.op_count !== 8'h00) begin
            $display("FAIL rst_mid: got acc=%h v=%b cnt=%h want 00 0 00", bus.res_acc, bus.res_valid, bus.op_count); nfail++; end
        nchk++; if (bus.cmd_ready !== 1'b0) begin $display("FAIL rst_mid_ready: got %b want 0", bus.cmd_ready); nfail++; end
        rst = 1'b0;
        @(negedge clk);
        nchk++; if (bus.cmd_ready !== 1'b1) begin $display("FAIL rst_mid_release: got %b want 1", bus.cmd_ready); nfail++; end
    endtask

    task automatic test_wrap();
        for (int i = 0; i < 255; i++) run_cmd(1'b1, 3'b000, i[7:0]);
        @(negedge clk);
        nchk++; if (bus.op_count !== 8'hFF) begin $display("FAIL wrap_ff: got %h want FF", bus.op_count); nfail++; end
        run_cmd(1'b1, 3'b000, 8'hAA);
        @(negedge clk);
        nchk++; if (bus.op_count !== 8'h00) begin $display("FAIL wrap_00: got %h want 00", bus.op_count); nfail++; end
    endtask

    initial begin
        bus.cmd_valid = 1'b0;
        bus.cmd_load  = 1'b0;
        bus.cmd_op    = 3'b000;
        bus.cmd_data  = 8'h00;
        bus.res_ready = 1'b1;
        test_reset();
        test_add();
        test_overflow();
        test_sub_cmp();
        test_zero();
        test_backpressure();
        test_reset_mid();
        test_wrap();
        $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
        $finish;
    end
endmodule
